// File: rtl/turno_controlador.sv
// Turn scheduler for the 5x5 naval game: alternates player/PC shots, picks PC cells, counts hits, declares winner.
// Latency: valid btn_fire -> disparo 1 cycle; shot_done -> next side's state 2 cycles; PC pick up to 31 cycles.
// Backpressure: disparo and x/y/turno are held until shot_done; btn_fire and shot_done are dropped outside the states that consume them.
module turno_controlador #(
  parameter int          N_SHIPS     = 3,
  parameter int          TIMEOUT_CYC = 50_000_000,
  parameter logic [4:0]  LFSR_SEED   = 5'b10101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_fire,
  input  logic [2:0] px,
  input  logic [2:0] py,
  input  logic       shot_done,
  input  logic       shot_hit,
  output logic       turno,
  output logic       disparo,
  output logic [2:0] estado,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [4:0] player_hits,
  output logic [4:0] pc_hits,
  output logic       shot_reject,
  output logic       game_over,
  output logic       winner
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_P_WAIT, S_P_SHOT, S_P_RES, S_PC_PICK, S_PC_SHOT, S_PC_RES, S_GAME_OVER
  } state_t;

  state_t        state, state_nxt;
  logic [24:0]   mask_p, mask_pc;
  logic [CW-1:0] tmo_cnt;
  logic [4:0]    lfsr;

  logic          in_range, fire_ok, tmo_hit, auto_ok, pc_ok;
  logic [4:0]    fire_idx, auto_idx, pc_v;
  logic [2:0]    auto_x, auto_y, pc_x, pc_y;

  assign in_range = (px <= 3'd4) && (py <= 3'd4);
  assign fire_idx = 5'({2'b00, px} * 5'd5 + {2'b00, py});
  assign fire_ok  = btn_fire && in_range && !mask_p[fire_idx];
  assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT_CYC - 1));
  assign pc_v     = lfsr - 5'd1;
  assign pc_ok    = (pc_v < 5'd25) && !mask_pc[pc_v];

  // Lowest-index free player cell for the timeout auto-shot; scanning downward leaves the lowest one.
  always_comb begin
    auto_ok  = 1'b0;
    auto_idx = 5'd0;
    auto_x   = 3'd0;
    auto_y   = 3'd0;
    for (int i = 24; i >= 0; i--) begin
      if (!mask_p[i]) begin
        auto_ok  = 1'b1;
        auto_idx = 5'(i);
        auto_x   = 3'(i / 5);
        auto_y   = 3'(i % 5);
      end
    end
  end

  // Split the LFSR candidate index into row/column without a divider.
  always_comb begin
    pc_x = 3'd0;
    pc_y = 3'd0;
    for (int i = 0; i < 25; i++) begin
      if (5'(i) == pc_v) begin
        pc_x = 3'(i / 5);
        pc_y = 3'(i % 5);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs; the win check sits ahead of the turn change.
  always_comb begin
    state_nxt = state;
    disparo   = 1'b0;
    game_over = 1'b0;
    estado    = 3'b000;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_P_WAIT;
      end
      S_P_WAIT: begin
        estado = 3'b001;
        if (fire_ok || (tmo_hit && auto_ok)) state_nxt = S_P_SHOT;
      end
      S_P_SHOT: begin
        estado  = 3'b010;
        disparo = 1'b1;
        if (shot_done) state_nxt = S_P_RES;
      end
      S_P_RES: begin
        estado    = 3'b010;
        state_nxt = (player_hits == 5'(N_SHIPS)) ? S_GAME_OVER : S_PC_PICK;
      end
      S_PC_PICK: begin
        estado = 3'b001;
        if (pc_ok) state_nxt = S_PC_SHOT;
      end
      S_PC_SHOT: begin
        estado  = 3'b010;
        disparo = 1'b1;
        if (shot_done) state_nxt = S_PC_RES;
      end
      S_PC_RES: begin
        estado    = 3'b010;
        state_nxt = (pc_hits == 5'(N_SHIPS)) ? S_GAME_OVER : S_P_WAIT;
      end
      S_GAME_OVER: begin
        estado    = 3'b100;
        game_over = 1'b1;
        if (start) state_nxt = S_P_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shot datapath: target latching, used-cell masks, hit counters, timeout counter and free-running LFSR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr        <= LFSR_SEED;
      tmo_cnt     <= '0;
      mask_p      <= '0;
      mask_pc     <= '0;
      turno       <= 1'b0;
      x           <= 3'd0;
      y           <= 3'd0;
      player_hits <= 5'd0;
      pc_hits     <= 5'd0;
      shot_reject <= 1'b0;
      winner      <= 1'b0;
    end else begin
      lfsr        <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      shot_reject <= 1'b0;
      // Counter only runs while the player is deciding; it wraps if the board has no free cell left.
      tmo_cnt     <= (state == S_P_WAIT && !tmo_hit) ? tmo_cnt + CW'(1) : '0;
      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (start) begin
            mask_p      <= '0;
            mask_pc     <= '0;
            player_hits <= 5'd0;
            pc_hits     <= 5'd0;
            winner      <= 1'b0;
          end
        end
        S_P_WAIT: begin
          if (fire_ok) begin
            x                <= px;
            y                <= py;
            turno            <= 1'b1;
            mask_p[fire_idx] <= 1'b1;
          end else if (tmo_hit && auto_ok) begin
            x                <= auto_x;
            y                <= auto_y;
            turno            <= 1'b1;
            mask_p[auto_idx] <= 1'b1;
          end
          if (btn_fire && !fire_ok) shot_reject <= 1'b1;
        end
        S_P_SHOT: begin
          if (shot_done && shot_hit && player_hits != 5'(N_SHIPS))
            player_hits <= player_hits + 5'd1;
        end
        S_P_RES: begin
          if (player_hits == 5'(N_SHIPS)) winner <= 1'b1;
        end
        S_PC_PICK: begin
          if (pc_ok) begin
            x             <= pc_x;
            y             <= pc_y;
            turno         <= 1'b0;
            mask_pc[pc_v] <= 1'b1;
          end
        end
        S_PC_SHOT: begin
          if (shot_done && shot_hit && pc_hits != 5'(N_SHIPS))
            pc_hits <= pc_hits + 5'd1;
        end
        S_PC_RES: begin
          if (pc_hits == 5'(N_SHIPS)) winner <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turno_controlador.sv
// Directed bench for turno_controlador with a short timeout and three ships per side.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Every wait on the DUT is bounded so the run always reaches the summary line.
module tb_turno_controlador;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, btn_fire, shot_done, shot_hit;
  logic [2:0] px, py;
  logic       turno, disparo, shot_reject, game_over, winner;
  logic [2:0] estado, x, y;
  logic [4:0] player_hits, pc_hits;

  int   total = 0;
  int   bad   = 0;
  logic pc_seen [25];

  turno_controlador #(
    .N_SHIPS     (3),
    .TIMEOUT_CYC (10),
    .LFSR_SEED   (5'b10101)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .btn_fire    (btn_fire),
    .px          (px),
    .py          (py),
    .shot_done   (shot_done),
    .shot_hit    (shot_hit),
    .turno       (turno),
    .disparo     (disparo),
    .estado      (estado),
    .x           (x),
    .y           (y),
    .player_hits (player_hits),
    .pc_hits     (pc_hits),
    .shot_reject (shot_reject),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 25; i++) pc_seen[i] = 1'b0;
  endtask

  task automatic do_reset_start();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_seen();
  endtask

  // Player fires at (cx,cy), handshake held one extra cycle, then shot_done with the given result.
  task automatic player_round(input logic [2:0] cx, input logic [2:0] cy, input logic hit);
    btn_fire = 1'b1; px = cx; py = cy;
    tick();
    btn_fire = 1'b0;
    chk("p_disparo", disparo, 1);
    chk("p_turno", turno, 1);
    chk("p_x", x, cx);
    chk("p_y", y, cy);
    tick();
    chk("p_hold", disparo, 1);
    chk("p_hold_x", x, cx);
    shot_done = 1'b1; shot_hit = hit;
    tick();
    shot_done = 1'b0; shot_hit = 1'b0;
    chk("p_drop", disparo, 0);
    tick();
  endtask

  // Waits for the PC shot, checks it lands on a fresh on-board cell, then acknowledges it.
  task automatic pc_round(input logic hit);
    int n;
    int idx;
    n = 0;
    while (!disparo && n < 40) begin
      tick();
      n++;
    end
    chk("pc_disparo", disparo, 1);
    chk("pc_turno", turno, 0);
    chk("pc_range", (x <= 3'd4 && y <= 3'd4), 1);
    if (x <= 3'd4 && y <= 3'd4) begin
      idx = int'(x) * 5 + int'(y);
      chk("pc_cell_new", pc_seen[idx], 0);
      pc_seen[idx] = 1'b1;
    end
    shot_done = 1'b1; shot_hit = hit;
    tick();
    shot_done = 1'b0; shot_hit = 1'b0;
    chk("pc_drop", disparo, 0);
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; btn_fire = 1'b0; shot_done = 1'b0; shot_hit = 1'b0;
    px = 3'd0; py = 3'd0;
    clear_seen();

    // Reset state
    #12;
    chk("rst_estado", estado, 0);
    chk("rst_disparo", disparo, 0);
    chk("rst_turno", turno, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_phits", player_hits, 0);
    chk("rst_pchits", pc_hits, 0);
    chk("rst_reject", shot_reject, 0);
    chk("rst_gover", game_over, 0);
    chk("rst_winner", winner, 0);
    reset = 1'b0;
    tick();

    // 1: reset in the middle of a player handshake
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_estado_wait", estado, 3'b001);
    btn_fire = 1'b1; px = 3'd2; py = 3'd3;
    tick();
    btn_fire = 1'b0;
    chk("t1_disparo_up", disparo, 1);
    reset = 1'b1;
    #1;
    chk("t1_rst_disparo", disparo, 0);
    chk("t1_rst_estado", estado, 0);
    chk("t1_rst_turno", turno, 0);
    chk("t1_rst_x", x, 0);
    chk("t1_rst_y", y, 0);
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_restart", estado, 3'b001);

    // 2: player hit at (2,3), then 25 PC shots that never repeat a cell
    clear_seen();
    btn_fire = 1'b1; px = 3'd2; py = 3'd3;
    tick();
    btn_fire = 1'b0;
    chk("t2_disparo", disparo, 1);
    chk("t2_x", x, 2);
    chk("t2_y", y, 3);
    chk("t2_turno", turno, 1);
    shot_done = 1'b1; shot_hit = 1'b1;
    tick();
    shot_done = 1'b0; shot_hit = 1'b0;
    chk("t2_drop", disparo, 0);
    chk("t2_phits", player_hits, 1);
    chk("t2_estado_res", estado, 3'b010);
    tick();
    chk("t2_estado_pick", estado, 3'b001);
    pc_round(1'b0);
    chk("t2_back_wait", estado, 3'b001);
    for (int i = 0; i < 25; i++) begin
      if (i != 13) begin
        player_round(3'(i / 5), 3'(i % 5), 1'b0);
        pc_round(1'b0);
      end
    end
    chk("t2_phits_end", player_hits, 1);
    chk("t2_pchits_end", pc_hits, 0);

    // 3: out-of-range and repeated shots are refused; stray shot_done is ignored
    do_reset_start();
    btn_fire = 1'b1; px = 3'd5; py = 3'd1;
    tick();
    btn_fire = 1'b0;
    chk("t3_rej_range", shot_reject, 1);
    chk("t3_rej_range_disp", disparo, 0);
    chk("t3_rej_range_est", estado, 3'b001);
    tick();
    chk("t3_rej_pulse_end", shot_reject, 0);
    player_round(3'd2, 3'd3, 1'b0);
    pc_round(1'b1);
    chk("t3_pchits", pc_hits, 1);
    for (int k = 0; k < 2; k++) begin
      btn_fire = 1'b1; px = 3'd2; py = 3'd3;
      tick();
      btn_fire = 1'b0;
      chk("t3_rej_repeat", shot_reject, 1);
      chk("t3_rej_repeat_disp", disparo, 0);
      chk("t3_rej_repeat_est", estado, 3'b001);
      tick();
      chk("t3_rej_repeat_end", shot_reject, 0);
    end
    shot_done = 1'b1; shot_hit = 1'b1;
    tick();
    shot_done = 1'b0; shot_hit = 1'b0;
    chk("t3_stray_done_hits", player_hits, 0);
    chk("t3_stray_done_est", estado, 3'b001);

    // 4: timeout auto-fire picks lowest free cell (0,2) after cells 0 and 1 are used
    do_reset_start();
    player_round(3'd0, 3'd0, 1'b0);
    pc_round(1'b0);
    player_round(3'd0, 3'd1, 1'b0);
    pc_round(1'b0);
    n = 0;
    while (!disparo && n < 20) begin
      tick();
      n++;
    end
    chk("t4_tmo_cycles", n, 10);
    chk("t4_tmo_x", x, 0);
    chk("t4_tmo_y", y, 2);
    chk("t4_tmo_turno", turno, 1);

    // 5: three player hits end the game with no PC shot afterwards
    do_reset_start();
    player_round(3'd0, 3'd0, 1'b1);
    pc_round(1'b0);
    player_round(3'd1, 3'd1, 1'b1);
    pc_round(1'b0);
    player_round(3'd4, 3'd4, 1'b1);
    chk("t5_gover", game_over, 1);
    chk("t5_winner", winner, 1);
    chk("t5_estado", estado, 3'b100);
    chk("t5_phits", player_hits, 3);
    n = 0;
    for (int k = 0; k < 35; k++) begin
      tick();
      if (disparo) n++;
    end
    chk("t5_no_pc_shot", n, 0);
    chk("t5_still_over", estado, 3'b100);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_restart_est", estado, 3'b001);
    chk("t5_restart_hits", player_hits, 0);
    chk("t5_restart_gover", game_over, 0);
    chk("t5_restart_winner", winner, 0);

    // 6: a valid btn_fire on the timeout cycle wins over the auto-shot
    do_reset_start();
    repeat (9) tick();
    chk("t6_pre_disparo", disparo, 0);
    btn_fire = 1'b1; px = 3'd3; py = 3'd4;
    tick();
    btn_fire = 1'b0;
    chk("t6_disparo", disparo, 1);
    chk("t6_x", x, 3);
    chk("t6_y", y, 4);
    chk("t6_turno", turno, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
